uart_rx_fifo: RTL

Serial front end for the colour-configuration path. It deserialises 8N1 UART frames from the board RX pin using 16x oversampling and buffers the received bytes in a first-word-fall-through FIFO. It presents RXD_Data/Empty to the Color_Manager, which consumes one byte per Rd_En pulse. It also reports framing errors and overflow.

---
 rtl/uart_rx_fifo_pkg.sv | 20 ++
 rtl/uart_rx_fifo_byte_fifo.sv | 61 ++++++
 rtl/uart_rx_fifo.sv | 135 +++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants and FSM encoding for the UART receive front end.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package uart_rx_fifo_pkg;

   localparam int UART_DATA_WIDTH = 8;
   localparam int OVERSAMPLE      = 16;
   localparam int MID_START       = 7;
   localparam int MID_BIT         = 15;
   localparam int SAMP_W          = $clog2(OVERSAMPLE);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo_byte_fifo.sv
// First-word-fall-through byte FIFO with registered fill count and overflow pulse.
// Latency: a write is visible at Rd_Data the cycle after the write edge; pops take effect in one cycle.
// Backpressure: none upstream; a write while full with no pop is dropped and flagged on Overflow.
module byte_fifo #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Wr_En,
   input  logic [DATA_W-1:0] Wr_Data,
   input  logic              Rd_En,
   output logic [DATA_W-1:0] Rd_Data,
   output logic              Empty,
   output logic              Full,
   output logic [ADDR_W:0]   Fill_Level,
   output logic              Overflow
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count;
   logic              rd_ok;
   logic              wr_ok;

   assign Empty      = (count == '0);
   assign Full       = (count == (ADDR_W+1)'(DEPTH));
   assign Fill_Level = count;
   assign Rd_Data    = Empty ? '0 : mem[rd_ptr];

   // A pop frees the slot in the same cycle, so a full FIFO still accepts a simultaneous write.
   assign rd_ok = Rd_En & ~Empty;
   assign wr_ok = Wr_En & (~Full | rd_ok);

   // Storage array; contents are meaningless until the pointers cover them, so no reset.
   always_ff @(posedge Clk) begin
      if (wr_ok) mem[wr_ptr] <= Wr_Data;
   end

   // Pointer, occupancy and overflow-pulse bookkeeping.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         Overflow <= 1'b0;
      end else begin
         Overflow <= Wr_En & Full & ~rd_ok;
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a FWFT byte FIFO, with framing/overflow pulses.
// Latency: stop bit sampled at end of tick cycle T, FIFO written at end of T+1, data visible from T+2.
// Backpressure: none on the serial line; bytes arriving while the FIFO is full are dropped (Overflow).
module uart_rx_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter int TICK_DIV        = 27,
   parameter int FIFO_DEPTH      = 8,
   parameter int FIFO_ADDR_WIDTH = 3,
   parameter int UART_DATA_WIDTH = uart_rx_fifo_pkg::UART_DATA_WIDTH
) (
   input  logic                       Clk,
   input  logic                       Rst,
   input  logic                       Rx,
   input  logic                       Rd_En,
   output logic [UART_DATA_WIDTH-1:0] RXD_Data,
   output logic                       Empty,
   output logic                       Full,
   output logic [FIFO_ADDR_WIDTH:0]   Fill_Level,
   output logic                       Frame_Err,
   output logic                       Overflow
);

   localparam int TCW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int BIT_W = (UART_DATA_WIDTH > 1) ? $clog2(UART_DATA_WIDTH) : 1;

   logic                       rx_meta;
   logic                       rx_s;
   logic [TCW-1:0]             tick_cnt;
   logic                       tick;
   rx_state_t                  state;
   logic [SAMP_W-1:0]          samp_cnt;
   logic [BIT_W-1:0]           bit_cnt;
   logic [UART_DATA_WIDTH-1:0] shift_reg;
   logic                       byte_vld;

   // Two-flop synchroniser; idles high so reset never looks like a start bit.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= Rx;
         rx_s    <= rx_meta;
      end
   end

   assign tick = (tick_cnt == TCW'(TICK_DIV - 1));

   // Free-running oversample tick divider.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) tick_cnt <= '0;
      else      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
   end

   // Receive FSM: start validation, LSB-first data capture, stop check and break recovery.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state     <= IDLE;
         samp_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         byte_vld  <= 1'b0;
         Frame_Err <= 1'b0;
      end else begin
         byte_vld  <= 1'b0;
         Frame_Err <= 1'b0;
         if (tick) begin
            case (state)
               IDLE: begin
                  if (!rx_s) begin
                     state    <= START;
                     samp_cnt <= '0;
                  end
               end
               START: begin
                  if (samp_cnt == SAMP_W'(MID_START)) begin
                     samp_cnt <= '0;
                     bit_cnt  <= '0;
                     state    <= rx_s ? IDLE : DATA;
                  end else begin
                     samp_cnt <= samp_cnt + 1'b1;
                  end
               end
               DATA: begin
                  if (samp_cnt == SAMP_W'(MID_BIT)) begin
                     samp_cnt  <= '0;
                     shift_reg <= {rx_s, shift_reg[UART_DATA_WIDTH-1:1]};
                     bit_cnt   <= bit_cnt + 1'b1;
                     if (bit_cnt == BIT_W'(UART_DATA_WIDTH - 1)) state <= STOP;
                  end else begin
                     samp_cnt <= samp_cnt + 1'b1;
                  end
               end
               STOP: begin
                  if (samp_cnt == SAMP_W'(MID_BIT)) begin
                     samp_cnt <= '0;
                     if (rx_s) begin
                        byte_vld <= 1'b1;
                        state    <= IDLE;
                     end else begin
                        Frame_Err <= 1'b1;
                        state     <= WAIT_HIGH;
                     end
                  end else begin
                     samp_cnt <= samp_cnt + 1'b1;
                  end
               end
               WAIT_HIGH: begin
                  if (rx_s) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   byte_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .ADDR_W (FIFO_ADDR_WIDTH),
      .DATA_W (UART_DATA_WIDTH)
   ) u_fifo (
      .Clk        (Clk),
      .Rst        (Rst),
      .Wr_En      (byte_vld),
      .Wr_Data    (shift_reg),
      .Rd_En      (Rd_En),
      .Rd_Data    (RXD_Data),
      .Empty      (Empty),
      .Full       (Full),
      .Fill_Level (Fill_Level),
      .Overflow   (Overflow)
   );

endmodule
